// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode-side handshake.
// master = fetch unit, slave = memory/decode environment.
interface inst_fetch_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] InstPC;
  logic [XLEN-1:0] InstPCPlus4;
  logic [1:0]      PCSrc;
  logic [XLEN-1:0] ImmExt;
  logic [XLEN-1:0] ALUResult;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, Instr, InstPC, InstPCPlus4, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, PCSrc, ImmExt, ALUResult
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, Instr, InstPC, InstPCPlus4, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, PCSrc, ImmExt, ALUResult
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, prefetches into a small in-order buffer, computes next PC
// at each decode consume and flushes/drains stale responses on redirect.
module inst_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] buf_data_q [BUF_DEPTH];
  logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic            req_valid, hs, consume;
  logic            push, pop, flush;
  logic [SW-1:0]   credit_used;
  logic [CW-1:0]   out_next;
  logic [XLEN-1:0] head_pc, seq_pc, target, rsp_pc;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Decode-side view of the buffer head
  assign head_pc         = buf_pc_q[head_q];
  assign seq_pc          = head_pc + XLEN'(4);
  assign bus.inst_valid  = (state_q == RUN) && (count_q != '0);
  assign bus.Instr       = buf_data_q[head_q];
  assign bus.InstPC      = head_pc;
  assign bus.InstPCPlus4 = seq_pc;
  assign bus.fetch_fault = fault_q;
  assign consume         = bus.inst_valid && bus.inst_ready;

  // A head popped this cycle frees its slot, so a new request may issue alongside it
  assign credit_used        = SW'(count_q) + SW'(out_q) - SW'(consume);
  assign req_valid          = (state_q == RUN) && (credit_used < SW'(BUF_DEPTH));
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;
  assign hs                 = req_valid && bus.imem_req_ready;

  // Outstanding requests are the last out_q sequential addresses, oldest first
  assign rsp_pc   = fetch_pc_q - (XLEN'(out_q) << 2);
  assign out_next = out_q + CW'(hs) - CW'(bus.imem_rsp_valid);

  always_comb begin
    case (bus.PCSrc)
      2'b01:   target = head_pc + bus.ImmExt;
      2'b10:   target = {bus.ALUResult[XLEN-1:1], 1'b0};
      default: target = seq_pc;
    endcase
  end

  // Next-state and control
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    fault_d    = fault_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (consume && (target[1:0] != 2'b00)) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (consume && (target != seq_pc)) begin
          // Same-cycle response is discarded; same-cycle request joins the drop count
          flush      = 1'b1;
          fetch_pc_d = target;
          out_d      = '0;
          drop_d     = out_next;
          state_d    = (out_next != '0) ? DRAIN : RUN;
        end else begin
          push  = bus.imem_rsp_valid;
          pop   = consume;
          out_d = out_next;
          if (hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      DRAIN: begin
        if (drop_q == '0) begin
          state_d = RUN;
        end else if (bus.imem_rsp_valid) begin
          drop_d = drop_q - CW'(1);
          if (drop_q == CW'(1)) state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
    end
  end

  // In-order instruction buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[PW'(i)] <= '0;
        buf_pc_q[PW'(i)]   <= RESET_PC;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_data_q[tail_q] <= bus.imem_rsp_data;
        buf_pc_q[tail_q]   <= rsp_pc;
        tail_q             <= next_ptr(tail_q);
      end
      if (pop) head_q <= next_ptr(head_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: fixed-latency in-order memory model and
// a scoreboard of expected fetch PCs popped at each decode consume.
module tb_inst_fetch_unit;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned BUF_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if #(.XLEN(XLEN)) ifc ();

  inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int passed = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int mem_lat   = 1;
  int cyc       = 0;
  int hs_total  = 0;
  int rsp_total = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: accepts at the edge, answers after mem_lat cycles, in order
  initial begin
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) mq.delete();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = word_of(mq[0].addr);
        void'(mq.pop_front());
        rsp_total++;
      end else begin
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (!rst && ifc.imem_req_valid && ifc.imem_req_ready) begin
        mq.push_back('{ifc.imem_addr, cyc + mem_lat});
        hs_total++;
      end
    end
  end

  always @(negedge clk)
    if (!rst) assert (!(dut.push && !dut.pop && int'(dut.count_q) == BUF_DEPTH))
      else $error("instruction buffer overflow");

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic req_rdy, input logic dec_rdy, input int lat);
    rst = 1'b1;
    mem_lat = lat;
    ifc.imem_req_ready = req_rdy;
    ifc.inst_ready     = dec_rdy;
    ifc.PCSrc          = 2'b00;
    ifc.ImmExt         = '0;
    ifc.ALUResult      = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    ifc.PCSrc          = 2'b00;
    ifc.ImmExt         = '0;
    ifc.ALUResult      = '0;
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (ifc.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", ifc.imem_req_valid); else passed++;
    checks++; if (ifc.inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b expected 0", ifc.inst_valid); else passed++;
    checks++; if (ifc.fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b expected 0", ifc.fetch_fault); else passed++;
    checks++; if (ifc.Instr !== 32'h0) $display("FAIL rst_instr: got %h expected 0", ifc.Instr); else passed++;
    checks++; if (ifc.InstPC !== 32'h0) $display("FAIL rst_instpc: got %h expected 0", ifc.InstPC); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset(1'b1, 1'b1, 1);
    for (int a = 0; a < 8; a++) sb.push_back(32'(a * 4));
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k < 2) begin
        checks++; if (ifc.inst_valid !== 1'b0) $display("FAIL seq_early_valid: cycle %0d got %b expected 0", k, ifc.inst_valid); else passed++;
      end else begin
        checks++; if (ifc.inst_valid !== 1'b1) $display("FAIL seq_bubble: cycle %0d got %b expected 1", k, ifc.inst_valid); else passed++;
      end
      if (ifc.inst_valid && ifc.inst_ready && sb.size() > 0) begin
        exp = sb.pop_front();
        checks++; if (ifc.InstPC !== exp) $display("FAIL seq_pc: got %h expected %h", ifc.InstPC, exp); else passed++;
        checks++; if (ifc.Instr !== word_of(exp)) $display("FAIL seq_instr: got %h expected %h", ifc.Instr, word_of(exp)); else passed++;
        checks++; if (ifc.InstPCPlus4 !== exp + 32'd4) $display("FAIL seq_pc4: got %h expected %h", ifc.InstPCPlus4, exp + 32'd4); else passed++;
      end
    end
    checks++; if (sb.size() != 0) $display("FAIL seq_drain: got %0d pending expected 0", sb.size()); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int consumed = 0;
    int hs0;
    do_reset(1'b1, 1'b1, 1);
    hs0 = hs_total;
    for (int a = 0; a < 8; a++) sb.push_back(32'(a * 4));
    for (int cy = 0; cy < 40 && sb.size() > 0; cy++) begin
      tick();
      ifc.inst_ready = !(cy >= 4 && cy < 9);
      #1;
      checks++; if ((hs_total - hs0) - consumed > BUF_DEPTH) $display("FAIL bp_inflight: got %0d expected <= %0d", (hs_total - hs0) - consumed, BUF_DEPTH); else passed++;
      if (cy == 8) begin
        checks++; if (ifc.imem_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b expected 0", ifc.imem_req_valid); else passed++;
      end
      if (ifc.inst_valid && ifc.inst_ready) begin
        exp = sb.pop_front();
        consumed++;
        checks++; if (ifc.InstPC !== exp) $display("FAIL bp_order: got %h expected %h", ifc.InstPC, exp); else passed++;
      end
    end
    checks++; if (sb.size() != 0) $display("FAIL bp_timeout: got %0d pending expected 0", sb.size()); else passed++;
  endtask

  task automatic test_branch();
    logic [31:0] exp;
    int redirect_cy = -1;
    int mark = 0;
    logic resumed = 1'b0;
    do_reset(1'b1, 1'b1, 3);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    sb.push_back(32'h48); sb.push_back(32'h4C);
    for (int cy = 0; cy < 80 && sb.size() > 0; cy++) begin
      tick();
      ifc.PCSrc  = 2'b00;
      ifc.ImmExt = '0;
      if (redirect_cy >= 0 && cy > redirect_cy && !resumed && ifc.imem_req_valid) begin
        resumed = 1'b1;
        checks++; if (ifc.imem_addr !== 32'h48) $display("FAIL br_resume_addr: got %h expected 00000048", ifc.imem_addr); else passed++;
        checks++; if (rsp_total - mark != 2) $display("FAIL br_stale_count: got %0d expected 2", rsp_total - mark); else passed++;
        checks++; if (ifc.inst_valid !== 1'b0) $display("FAIL br_stale_visible: got %b expected 0", ifc.inst_valid); else passed++;
      end
      if (ifc.inst_valid) begin
        exp = sb.pop_front();
        checks++; if (ifc.InstPC !== exp) $display("FAIL br_order: got %h expected %h", ifc.InstPC, exp); else passed++;
        if (exp == 32'h8) begin
          ifc.PCSrc   = 2'b01;
          ifc.ImmExt  = 32'h40;
          redirect_cy = cy;
          mark        = rsp_total - int'(ifc.imem_rsp_valid);
        end
      end
    end
    checks++; if (resumed !== 1'b1 || sb.size() != 0) $display("FAIL br_timeout: got resumed=%b pending=%0d expected 1/0", resumed, sb.size()); else passed++;
  endtask

  task automatic test_jalr();
    logic [31:0] exp;
    do_reset(1'b1, 1'b1, 1);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h100); sb.push_back(32'h104);
    for (int cy = 0; cy < 40 && sb.size() > 0; cy++) begin
      tick();
      ifc.PCSrc     = 2'b00;
      ifc.ALUResult = '0;
      if (ifc.inst_valid) begin
        exp = sb.pop_front();
        checks++; if (ifc.InstPC !== exp) $display("FAIL jalr_order: got %h expected %h", ifc.InstPC, exp); else passed++;
        if (exp == 32'h4) begin
          ifc.PCSrc     = 2'b10;
          ifc.ALUResult = 32'h101;
          checks++; if (ifc.InstPCPlus4 !== 32'h8) $display("FAIL jalr_pc4: got %h expected 00000008", ifc.InstPCPlus4); else passed++;
        end
      end
    end
    checks++; if (sb.size() != 0) $display("FAIL jalr_timeout: got %0d pending expected 0", sb.size()); else passed++;
  endtask

  task automatic test_misaligned();
    logic seen = 1'b0;
    do_reset(1'b1, 1'b1, 1);
    for (int cy = 0; cy < 10 && !seen; cy++) begin
      tick();
      if (ifc.inst_valid) begin
        seen       = 1'b1;
        ifc.PCSrc  = 2'b01;
        ifc.ImmExt = 32'h6;
      end
    end
    checks++; if (seen !== 1'b1) $display("FAIL mis_no_inst: got %b expected 1", seen); else passed++;
    tick();
    ifc.PCSrc  = 2'b00;
    ifc.ImmExt = '0;
    checks++; if (ifc.fetch_fault !== 1'b1) $display("FAIL mis_fault: got %b expected 1", ifc.fetch_fault); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ifc.imem_req_valid !== 1'b0 || ifc.inst_valid !== 1'b0)
        $display("FAIL mis_halt: got req=%b inst=%b expected 0/0", ifc.imem_req_valid, ifc.inst_valid); else passed++;
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (ifc.fetch_fault !== 1'b0) $display("FAIL mis_clear: got %b expected 0", ifc.fetch_fault); else passed++;
  endtask

  task automatic test_stall_reset();
    do_reset(1'b1, 1'b0, 1);
    tick();
    tick();
    ifc.imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++; if (ifc.imem_req_valid !== 1'b1) $display("FAIL stall_valid: cycle %0d got %b expected 1", i, ifc.imem_req_valid); else passed++;
      checks++; if (ifc.imem_addr !== 32'h4) $display("FAIL stall_addr: cycle %0d got %h expected 00000004", i, ifc.imem_addr); else passed++;
    end
    checks++; if (ifc.Instr !== word_of(32'h0)) $display("FAIL stall_buffered: got %h expected %h", ifc.Instr, word_of(32'h0)); else passed++;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ifc.imem_req_valid !== 1'b0) $display("FAIL areset_req_valid: got %b expected 0", ifc.imem_req_valid); else passed++;
    checks++; if (ifc.inst_valid !== 1'b0) $display("FAIL areset_inst_valid: got %b expected 0", ifc.inst_valid); else passed++;
    checks++; if (ifc.Instr !== 32'h0) $display("FAIL areset_instr: got %h expected 0", ifc.Instr); else passed++;
    checks++; if (ifc.InstPC !== 32'h0) $display("FAIL areset_instpc: got %h expected 0", ifc.InstPC); else passed++;
    checks++; if (ifc.imem_addr !== 32'h0) $display("FAIL areset_addr: got %h expected 0", ifc.imem_addr); else passed++;
    checks++; if (ifc.fetch_fault !== 1'b0) $display("FAIL areset_fault: got %b expected 0", ifc.fetch_fault); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_jalr();
    test_misaligned();
    test_stall_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
